// File: rtl/wave_pkg.sv
// Shared definitions for the wave analyzer and generator-side benches:
// FSM encoding, default sample/threshold constants, threshold clamping.
package wave_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEEK    = 2'd1,
    MEASURE = 2'd2
  } state_e;

  localparam int DEF_DW   = 8;
  localparam int DEF_CW   = 24;
  localparam int DEF_MID  = 128;
  localparam int DEF_HYST = 8;

  // Clamp a threshold into the representable unsigned sample range.
  function automatic int sat_lim(input int v, input int dw);
    int top;
    top = (1 << dw) - 1;
    if (v < 0)   return 0;
    if (v > top) return top;
    return v;
  endfunction

endpackage

// File: rtl/wave_cross_det.sv
// Registers the incoming sample and detects hysteresis-qualified rising
// crossings of the mid level; s and rx leave here aligned with each other.
module wave_cross_det
  import wave_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int MID  = DEF_MID,
  parameter int HYST = DEF_HYST
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] wave,
  output logic [DW-1:0] s,
  output logic          rx
);

  localparam int LO = sat_lim(MID - HYST, DW);
  localparam int HI = sat_lim(MID + HYST, DW);
  localparam logic [DW-1:0] LO_V = LO[DW-1:0];
  localparam logic [DW-1:0] HI_V = HI[DW-1:0];

  logic [DW-1:0] s1_q, s2_q;
  logic          arm_q, arm_d;
  logic          rx_q, rx_d;

  // A rising crossing consumes the arm; a low sample re-arms it.
  always_comb begin
    arm_d = arm_q;
    rx_d  = 1'b0;
    if (clr) begin
      arm_d = 1'b0;
    end else if (arm_q && (s1_q >= HI_V)) begin
      rx_d  = 1'b1;
      arm_d = 1'b0;
    end else if (s1_q < LO_V) begin
      arm_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      arm_q <= 1'b0;
      rx_q  <= 1'b0;
    end else begin
      s1_q  <= wave;
      s2_q  <= s1_q;
      arm_q <= arm_d;
      rx_q  <= rx_d;
    end
  end

  assign s  = s2_q;
  assign rx = rx_q;

endmodule

// File: rtl/wave_analyzer.sv
// Measures period and min/max/peak-to-peak of an unsigned sample stream,
// publishing one result per full waveform cycle between rising crossings.
module wave_analyzer
  import wave_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int CW   = DEF_CW,
  parameter int MID  = DEF_MID,
  parameter int HYST = DEF_HYST
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] wave,
  output logic [CW-1:0] period,
  output logic [DW-1:0] vmax,
  output logic [DW-1:0] vmin,
  output logic [DW-1:0] pkpk,
  output logic          valid,
  output logic          overflow,
  output logic          busy
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] cmax_q, cmax_d, cmin_q, cmin_d;
  logic [CW-1:0] period_q, period_d;
  logic [DW-1:0] vmax_q, vmax_d, vmin_q, vmin_d, pkpk_q, pkpk_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          en_q;

  logic [DW-1:0] s;
  logic          rx;
  logic [DW-1:0] hi_v, lo_v;

  wave_cross_det #(.DW(DW), .MID(MID), .HYST(HYST)) u_cross (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == IDLE),
    .wave (wave),
    .s    (s),
    .rx   (rx)
  );

  // Running extremes including the sample in hand.
  assign hi_v = (s > cmax_q) ? s : cmax_q;
  assign lo_v = (s < cmin_q) ? s : cmin_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmax_d   = cmax_q;
    cmin_d   = cmin_q;
    period_d = period_q;
    vmax_d   = vmax_q;
    vmin_d   = vmin_q;
    pkpk_d   = pkpk_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    if (en && !en_q) ovf_d = 1'b0;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = SEEK;
        SEEK: begin
          if (rx) begin
            state_d = MEASURE;
            cnt_d   = CW'(1);
            cmax_d  = s;
            cmin_d  = s;
          end
        end
        MEASURE: begin
          // A crossing on the saturated count still reports; rx has priority.
          if (rx) begin
            period_d = cnt_q;
            vmax_d   = hi_v;
            vmin_d   = lo_v;
            pkpk_d   = hi_v - lo_v;
            valid_d  = 1'b1;
            cnt_d    = CW'(1);
            cmax_d   = s;
            cmin_d   = s;
          end else if (cnt_q == CNT_MAX) begin
            ovf_d   = 1'b1;
            state_d = SEEK;
          end else begin
            cnt_d  = cnt_q + CW'(1);
            cmax_d = hi_v;
            cmin_d = lo_v;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cmax_q   <= '0;
      cmin_q   <= '0;
      period_q <= '0;
      vmax_q   <= '0;
      vmin_q   <= '0;
      pkpk_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmax_q   <= cmax_d;
      cmin_q   <= cmin_d;
      period_q <= period_d;
      vmax_q   <= vmax_d;
      vmin_q   <= vmin_d;
      pkpk_q   <= pkpk_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      en_q     <= en;
    end
  end

  assign period   = period_q;
  assign vmax     = vmax_q;
  assign vmin     = vmin_q;
  assign pkpk     = pkpk_q;
  assign valid    = valid_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_wave_analyzer.sv
// Bench for wave_analyzer: a window-based reference model checked every cycle,
// directed waveforms with literal expectations, then randomized segments.
module tb_wave_analyzer;

  localparam int DW   = 8;
  localparam int CW   = 6;
  localparam int MID  = 128;
  localparam int HYST = 8;
  localparam int LO   = 120;
  localparam int HI   = 136;
  localparam int MAXC = 63;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b0;
  logic [DW-1:0] wave = '0;
  logic [CW-1:0] period;
  logic [DW-1:0] vmax, vmin, pkpk;
  logic          valid, overflow, busy;

  int errors = 0;
  int checks = 0;
  int vcnt   = 0;

  wave_analyzer #(.DW(DW), .CW(CW), .MID(MID), .HYST(HYST)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .wave     (wave),
    .period   (period),
    .vmax     (vmax),
    .vmin     (vmin),
    .pkpk     (pkpk),
    .valid    (valid),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 looking for first crossing, 2 collecting a cycle window
  int s1, sp;
  bit rxp, arm, en_prev;
  int mode;
  int win[$];
  int m_period, m_vmax, m_vmin, m_pkpk;
  bit m_valid, m_ovf;

  task automatic model_reset();
    s1 = 0; sp = 0; rxp = 0; arm = 0; en_prev = 0; mode = 0;
    win.delete();
    m_period = 0; m_vmax = 0; m_vmin = 0; m_pkpk = 0; m_valid = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    bit rx_new;
    int mx, mn;
    rx_new = 0;
    if (mode == 0) arm = 0;
    else if (arm && s1 >= HI) begin rx_new = 1; arm = 0; end
    else if (s1 < LO) arm = 1;

    m_valid = 0;
    if (en && !en_prev) m_ovf = 0;
    if (!en) begin
      mode = 0;
      win.delete();
    end else if (mode == 0) begin
      mode = 1;
    end else if (mode == 1) begin
      if (rxp) begin mode = 2; win.delete(); win.push_back(sp); end
    end else begin
      if (rxp) begin
        mx = sp; mn = sp;
        foreach (win[i]) begin
          if (win[i] > mx) mx = win[i];
          if (win[i] < mn) mn = win[i];
        end
        m_period = win.size(); m_vmax = mx; m_vmin = mn; m_pkpk = mx - mn;
        m_valid = 1;
        win.delete(); win.push_back(sp);
      end else if (win.size() == MAXC) begin
        m_ovf = 1;
        mode = 1;
        win.delete();
      end else begin
        win.push_back(sp);
      end
    end
    sp = s1; rxp = rx_new; s1 = int'(wave); en_prev = en;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (valid) vcnt++;
        chk("valid",    int'(valid),    int'(m_valid));
        chk("busy",     int'(busy),     int'(mode != 0));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("period",   int'(period),   m_period);
        chk("vmax",     int'(vmax),     m_vmax);
        chk("vmin",     int'(vmin),     m_vmin);
        chk("pkpk",     int'(pkpk),     m_pkpk);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int w);
    wave = DW'(w);
    @(negedge clk);
  endtask

  task automatic square(input int lo_n, input int hi_n, input int lo_v, input int hi_v, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < lo_n; i++) drive(lo_v);
      for (int i = 0; i < hi_n; i++) drive(hi_v);
    end
  endtask

  task automatic pause(input int n);
    en = 1'b0;
    for (int i = 0; i < n; i++) drive(0);
    en = 1'b1;
  endtask

  initial begin
    int v0;
    rst = 1'b0; en = 1'b0; wave = '0;
    repeat (3) @(negedge clk);
    chk("rst_period", int'(period), 0);
    chk("rst_valid",  int'(valid),  0);
    chk("rst_busy",   int'(busy),   0);
    rst = 1'b1;
    @(negedge clk);

    // square wave, 4 low / 4 high
    en = 1'b1;
    v0 = vcnt;
    square(4, 4, 0, 255, 8);
    repeat (3) drive(0);
    chk("sq_period", int'(period), 8);
    chk("sq_vmax",   int'(vmax),   255);
    chk("sq_vmin",   int'(vmin),   0);
    chk("sq_pkpk",   int'(pkpk),   255);
    chk("sq_nvalid", vcnt - v0,    7);

    // triangle 10..250..10 step 10
    pause(2);
    v0 = vcnt;
    for (int r = 0; r < 4; r++) begin
      for (int v = 10; v <= 250; v += 10) drive(v);
      for (int v = 240; v >= 20; v -= 10) drive(v);
    end
    repeat (4) drive(10);
    chk("tri_period", int'(period), 48);
    chk("tri_vmax",   int'(vmax),   250);
    chk("tri_vmin",   int'(vmin),   10);
    chk("tri_pkpk",   int'(pkpk),   240);
    chk("tri_nvalid", vcnt - v0,    3);

    // in-band dither never crosses; wide dither crosses every 2 samples
    pause(2);
    v0 = vcnt;
    square(1, 1, 125, 131, 20);
    chk("band_nvalid", vcnt - v0, 0);
    square(1, 1, 100, 160, 10);
    chk("wide_period", int'(period), 2);
    chk("wide_vmax",   int'(vmax),   160);
    chk("wide_vmin",   int'(vmin),   100);
    chk("wide_pkpk",   int'(pkpk),   60);

    // overflow after one crossing then flat input
    pause(2);
    v0 = vcnt;
    repeat (4) drive(0);
    drive(255);
    repeat (70) drive(0);
    chk("ovf_set",    int'(overflow), 1);
    chk("ovf_busy",   int'(busy),     1);
    chk("ovf_period", int'(period),   2);
    chk("ovf_nvalid", vcnt - v0,      0);
    en = 1'b0;
    drive(0);
    chk("ovf_sticky", int'(overflow), 1);
    en = 1'b1;
    drive(0);
    chk("ovf_clear",  int'(overflow), 0);

    // crossing exactly on the saturated count is still a measurement
    pause(2);
    square(31, 32, 0, 255, 3);
    repeat (3) drive(0);
    chk("max_period", int'(period),   63);
    chk("max_ovf",    int'(overflow), 0);

    // enable dropped mid-period
    pause(2);
    square(4, 4, 0, 255, 2);
    repeat (4) drive(0);
    drive(255);
    en = 1'b0;
    drive(255);
    chk("drop_busy",   int'(busy),   0);
    chk("drop_period", int'(period), 8);
    en = 1'b1;
    square(4, 4, 0, 255, 4);

    // randomized segments
    for (int seg = 0; seg < 30; seg++) begin
      if ($urandom_range(0, 4) == 0) pause($urandom_range(1, 3));
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < 30; i++) drive($urandom_range(0, 255));
      end else begin
        square($urandom_range(1, 40), $urandom_range(1, 40),
               $urandom_range(0, LO - 1), $urandom_range(HI, 255), 3);
      end
    end

    // asynchronous reset while measuring
    pause(2);
    square(4, 4, 0, 255, 3);
    #2 rst = 1'b0;
    #1;
    chk("arst_period", int'(period), 0);
    chk("arst_vmax",   int'(vmax),   0);
    chk("arst_pkpk",   int'(pkpk),   0);
    chk("arst_busy",   int'(busy),   0);
    @(negedge clk);
    rst = 1'b1;
    square(4, 4, 0, 255, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
